// File: rtl/scrambler_pkg.sv
// Shared constants for the multi-lane additive scrambler: LFSR width,
// Galois tap mask for x^23+x^21+x^16+x^8+x^5+x^2+1 and the per-lane seeds.
package scrambler_pkg;

    localparam int LFSR_WIDTH = 23;

    // Bits that receive the feedback XOR after the shift (2,5,8,16,21).
    // Bit 0 takes the feedback bit directly through the rotate.
    localparam logic [LFSR_WIDTH-1:0] TAP_MASK = 23'h210124;

    // Lane n starts from SEED[n mod 8].
    localparam logic [LFSR_WIDTH-1:0] SEED [8] = '{
        23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
        23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
    };

    // Seed for a given lane index; the cast keeps the low three bits (mod 8).
    function automatic logic [LFSR_WIDTH-1:0] seed_for_lane(input int lane);
        return SEED[3'(lane)];
    endfunction

endpackage

// File: rtl/scrambler_lane.sv
// One scrambler lane: 23-bit Galois LFSR, DATA_WIDTH serial steps unrolled
// per beat, data XOR with the key stream and a bypass path for skip/seed.
module scrambler_lane
    import scrambler_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0]  SEED_VALUE = 23'h1DBFBC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance_i,   // accepted beat, normal scramble
    input  logic                  load_i,      // accepted beat, reload seed
    input  logic                  bypass_i,    // pass data through unscrambled
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;
    logic [LFSR_WIDTH-1:0] walk;
    logic [DATA_WIDTH-1:0] key;
    logic                  key_bit;

    // Unroll the serial steps: bit k of the beat uses the key of step k,
    // and walk ends up holding the state after a full beat.
    always_comb begin
        walk    = lfsr_q;
        key     = '0;
        key_bit = 1'b0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            key_bit = walk[LFSR_WIDTH-1];
            key[k]  = key_bit;
            walk    = {walk[LFSR_WIDTH-2:0], key_bit} ^ (key_bit ? TAP_MASK : '0);
        end
    end

    assign data_o = bypass_i ? data_i : (data_i ^ key);

    // Seed reload wins over advance; otherwise the state holds.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_VALUE;
        end else if (advance_i) begin
            lfsr_d = walk;
        end
    end

    // LFSR state register, returns to the lane seed on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED_VALUE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/lane_scrambler.sv
// Multi-lane additive scrambler with a single-register valid/ready stage.
// Optional macro LANE_SCRAMBLER_DISABLE_EN adds a scramble_disable input that
// forces bypass on every lane while the LFSRs keep their normal sequence.
module lane_scrambler
    import scrambler_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
`ifdef LANE_SCRAMBLER_DISABLE_EN
    input  logic                            scramble_disable,
`endif
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_LANES-1:0]            in_skip,
    input  logic [NUM_LANES-1:0]            in_seed,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]            out_skip
);

    logic                            accept;
    logic                            scramble_off;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data;

    logic                            out_valid_q, out_valid_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [NUM_LANES-1:0]            out_skip_q,  out_skip_d;

`ifdef LANE_SCRAMBLER_DISABLE_EN
    assign scramble_off = scramble_disable;
`else
    assign scramble_off = 1'b0;
`endif

    // The output register can take a beat when empty or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            scrambler_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .SEED_VALUE (seed_for_lane(gi))
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .advance_i (accept && !in_skip[gi] && !in_seed[gi]),
                .load_i    (accept && in_seed[gi]),
                .bypass_i  (in_skip[gi] || in_seed[gi] || scramble_off),
                .data_i    (in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .data_o    (lane_data[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // Load on accept, clear valid on a drain with no new beat, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_skip_d  = out_skip_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_data;
            out_skip_d  = in_skip | in_seed;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage register; reset discards any pending beat immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_skip_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_skip_q  <= out_skip_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_skip  = out_skip_q;

endmodule

// File: doc/lane_scrambler.md
LANE_SCRAMBLER -- requirements
Module: lane_scrambler

Interface
REQ-001 Parameter NUM_LANES, default 4: number of independent lanes, legal range 1..16.
REQ-002 Parameter DATA_WIDTH, default 32: bits per lane per beat, legal values 8, 16 or 32.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  beat present on the in_* lane buses.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_data  input  NUM_LANES*DATA_WIDTH  lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH]; bit 0 is first in time.
REQ-008 in_skip  input  NUM_LANES  per lane: pass the beat unscrambled and hold that lane's LFSR.
REQ-009 in_seed  input  NUM_LANES  per lane: pass the beat unscrambled, then reload that lane's LFSR with its seed.
REQ-010 out_valid  output  1  registered beat available.
REQ-011 out_ready  input  1  downstream accepts the beat.
REQ-012 out_data  output  NUM_LANES*DATA_WIDTH  scrambled or bypassed data, same lane mapping as in_data.
REQ-013 out_skip  output  NUM_LANES  registered copy of (in_skip | in_seed) for the accepted beat.

Function
REQ-014 Each lane SHALL hold a 23-bit Galois LFSR for the polynomial x^23+x^21+x^16+x^8+x^5+x^2+1.
REQ-015 Serial step: key bit = S[22]; S[0] <= S[22]; S[i] <= S[i-1] ^ S[22] for i in {2,5,8,16,21}; S[i] <= S[i-1] for all other i.
REQ-016 Scrambled bit k of a lane SHALL be in bit k XOR the key bit of serial step k; steps run k = 0..DATA_WIDTH-1, unrolled combinationally.
REQ-017 An accepted beat SHALL advance the lane's LFSR by exactly DATA_WIDTH serial steps when in_skip and in_seed are both 0 for that lane.
REQ-018 in_skip=1 on a lane SHALL give out_data equal to in_data and leave that lane's LFSR unchanged.
REQ-019 in_seed=1 on a lane SHALL give out_data equal to in_data and load LFSR := SEED[lane mod 8]; in_seed overrides in_skip.
REQ-020 in_skip and in_seed SHALL act only on accepted beats (in_valid & in_ready) and SHALL be ignored otherwise.
REQ-021 Handshake: in_ready = !out_valid | out_ready; latency from accepted beat to out_valid is 1 cycle; full throughput of 1 beat per cycle.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_skip and all LFSRs SHALL hold stable.
REQ-023 out_valid SHALL clear after an out_ready handshake unless a new beat is accepted in the same cycle.
REQ-024 Lanes SHALL be fully independent; skip or seed on one lane SHALL NOT affect any other lane.

Reset
REQ-025 While reset=1: out_valid=0, out_data=0, out_skip=0, and every lane LFSR = SEED[lane mod 8].
REQ-026 Reset asserted mid-stream SHALL discard the registered beat immediately; the first beat accepted after release SHALL use seed state.

Configuration
REQ-027 With macro LANE_SCRAMBLER_DISABLE_EN defined, an input port scramble_disable (1 bit) SHALL exist; when it is 1, all lanes SHALL pass data unscrambled while their LFSRs still advance per REQ-017..019.
REQ-028 Without LANE_SCRAMBLER_DISABLE_EN, the scramble_disable port SHALL be absent and scrambling is always active.

Structure
REQ-029 Package scrambler_pkg SHALL hold LFSR_WIDTH=23, the tap mask, and an 8-entry SEED table: 1DBFBC, 0607BB, 1EC760, 18C0DB, 010F12, 19CFC9, 0277CE, 1BB807 (hex).
REQ-030 Sub-module scrambler_lane SHALL implement one lane's LFSR, its DATA_WIDTH-step unroll and data XOR; the top level SHALL instantiate it NUM_LANES times and add the handshake register.

Verification
REQ-031 Reset release, NUM_LANES=4, hold in_valid=0 -> out_valid=0 and out_data=0; every LFSR matches its seed via a golden serial model.
REQ-032 Lane 0 in_skip=1 with data 0xA5A5A5A5, then a normal beat -> first out equals 0xA5A5A5A5; second out equals the model's first post-reset key XOR data.
REQ-033 Random data through lane_scrambler, then through a second instance -> original data recovered bit-exact over 10000 beats, all lanes.
REQ-034 out_ready=0 for 3 cycles mid-stream -> out_data held, in_ready=0, no LFSR advance; the stream stays model-exact after release.
REQ-035 NUM_LANES=16 with identical input on lanes 0 and 8 -> identical outputs; in_seed on lane 3 only -> lane 3 restarts from seed, other lanes unaffected.
REQ-036 Reset pulsed while out_valid=1 -> out_valid=0 within the same cycle; the next beat is scrambled with seed state.
